reg_frame_decoder: RTL and testbench

- Host-side byte-stream parser that produces the register-write bus consumed by the core layer.
- Assembles bytes from the host link receiver into a command byte plus a 16-bit value. Emits a one-clock write strobe per complete frame.
- Sits between the host byte receiver and the core layer's cmd/value/write inputs.
- Also handles framing errors, inter-byte timeout and frame/error statistics.

---
 rtl/reg_frame_decoder.sv | 127 ++++++++++++
 tb/tb_reg_frame_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_frame_decoder.sv
// Host byte-stream parser: assembles a command byte plus a big-endian 16-bit value
// into a one-clock register-write strobe, with framing-error, timeout and statistics.
module reg_frame_decoder #(
   parameter int TIMEOUT_CYCLES = 6400,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                 clock,
   input  logic                 Reset,
   input  logic                 enable,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           cmd,
   output logic [15:0]          value,
   output logic                 write,
   output logic                 frame_err,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, VAL_HI, VAL_LO} state_t;

   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [7:0]       cmd_lat_q;
   logic [7:0]       hi_q;
   logic             accept;
   logic             load_cmd, load_hi, write_d, err_d, wr_static;

   function automatic logic is_long(input logic [3:0] c);
      return ((c >= 4'h1) && (c <= 4'h6)) || (c == 4'h8);
   endfunction

   function automatic logic is_static(input logic [3:0] c);
      return c == 4'h7;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   assign accept = rx_valid & enable;
   assign busy   = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      load_cmd  = 1'b0;
      load_hi   = 1'b0;
      write_d   = 1'b0;
      err_d     = 1'b0;
      wr_static = 1'b0;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (accept) begin
               if (is_long(rx_data[3:0])) begin
                  load_cmd = 1'b1;
                  state_d  = VAL_HI;
               end else if (is_static(rx_data[3:0])) begin
                  write_d   = 1'b1;
                  wr_static = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         VAL_HI, VAL_LO: begin
            // An arriving byte beats a timeout that would expire on the same clock
            if (!enable) begin
               state_d = IDLE;
               tmo_d   = '0;
            end else if (accept) begin
               tmo_d = '0;
               if (state_q == VAL_HI) begin
                  load_hi = 1'b1;
                  state_d = VAL_LO;
               end else begin
                  write_d = 1'b1;
                  state_d = IDLE;
               end
            end else if (tmo_q == TMO_LIM) begin
               err_d   = 1'b1;
               state_d = IDLE;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         tmo_q       <= '0;
         write       <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         err_count   <= '0;
         cmd         <= '0;
         value       <= '0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         write     <= write_d;
         frame_err <= err_d;
         if (write_d) begin
            frame_count <= frame_count + CNT_WIDTH'(1);
            cmd         <= wr_static ? rx_data : cmd_lat_q;
            if (!wr_static) value <= {hi_q, rx_data};
         end
         if (err_d) err_count <= sat_inc(err_count);
      end
   end

   // Partial-frame holding registers; never visible until a write completes
   always_ff @(posedge clock) begin
      if (load_cmd) cmd_lat_q <= rx_data;
      if (load_hi)  hi_q      <= rx_data;
   end

endmodule

// File: tb/tb_reg_frame_decoder.sv
// Directed bench for reg_frame_decoder: expected writes go into a queue as frames
// are sent and are popped and compared when the decoder strobes write.
module tb_reg_frame_decoder;

   localparam int T  = 8;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          Reset = 1'b1;
   logic          enable = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic [7:0]    cmd;
   logic [15:0]   value;
   logic          write;
   logic          frame_err;
   logic          busy;
   logic [CW-1:0] frame_count;
   logic [CW-1:0] err_count;

   int            checks = 0;
   int            errors = 0;
   logic [23:0]   exp_q[$];
   logic [23:0]   e;
   logic [CW-1:0] exp_fc = '0;
   logic [CW-1:0] exp_ec = '0;
   int            writes_seen = 0;
   int            errs_seen = 0;
   int            exp_writes = 0;
   int            exp_errs = 0;

   reg_frame_decoder #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
      .clock(clock), .Reset(Reset), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
      .cmd(cmd), .value(value), .write(write), .frame_err(frame_err), .busy(busy),
      .frame_count(frame_count), .err_count(err_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clock);
      #1 rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic expect_write(input logic [7:0] c, input logic [15:0] v);
      exp_q.push_back({c, v});
      exp_writes++;
   endtask

   always @(negedge clock) begin
      if (!Reset) begin
         if (write) begin
            writes_seen++;
            exp_fc = exp_fc + 1'b1;
            chk("write_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("cmd", 32'(cmd), 32'(e[23:16]));
               chk("value", 32'(value), 32'(e[15:0]));
            end
            chk("frame_count", 32'(frame_count), 32'(exp_fc));
            chk("write_err_exclusive", 32'(frame_err), 32'd0);
         end
         if (frame_err) begin
            errs_seen++;
            if (exp_ec != '1) exp_ec = exp_ec + 1'b1;
            chk("err_count", 32'(err_count), 32'(exp_ec));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(2);
      Reset = 1'b0;
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      enable = 1'b1;
      idle(1);

      // Three-byte frame
      send(8'h01);
      chk("busy_after_cmd", 32'(busy), 32'd1);
      send(8'h00);
      chk("busy_after_hi", 32'(busy), 32'd1);
      expect_write(8'h01, 16'h0019);
      send(8'h19);
      chk("write_latency", 32'(write), 32'd1);
      chk("busy_after_lo", 32'(busy), 32'd0);
      idle(1);
      chk("write_one_clock", 32'(write), 32'd0);

      // Statics frames keep the previous value
      expect_write(8'h37, 16'h0019);
      send(8'h37);
      chk("statics_write", 32'(write), 32'd1);
      idle(1);
      expect_write(8'hB7, 16'h0019);
      send(8'hB7);
      chk("statics_cmd", 32'(cmd), 32'h00B7);

      // Invalid command class
      send(8'h0A);
      exp_errs++;
      chk("invalid_err", 32'(frame_err), 32'd1);
      chk("invalid_no_write", 32'(write), 32'd0);
      chk("invalid_cmd_hold", 32'(cmd), 32'h00B7);
      idle(1);
      chk("err_one_clock", 32'(frame_err), 32'd0);
      chk("err_count_1", 32'(err_count), 32'd1);

      // Timeout: T-1 silent clocks are tolerated, the T-th drops the frame
      send(8'h02);
      send(8'h00);
      idle(T - 1);
      chk("tmo_not_yet", 32'(frame_err), 32'd0);
      chk("tmo_still_busy", 32'(busy), 32'd1);
      idle(1);
      exp_errs++;
      chk("tmo_err", 32'(frame_err), 32'd1);
      chk("tmo_idle", 32'(busy), 32'd0);
      idle(3);
      chk("tmo_err_once", 32'(errs_seen), 32'(exp_errs));

      // Byte arriving on the limit clock wins
      send(8'h02);
      idle(T - 1);
      send(8'h00);
      chk("tmo_edge_no_err", 32'(frame_err), 32'd0);
      chk("tmo_edge_busy", 32'(busy), 32'd1);
      idle(T - 1);
      expect_write(8'h02, 16'h001E);
      send(8'h1E);
      chk("tmo_edge_write", 32'(write), 32'd1);
      chk("tmo_edge_value", 32'(value), 32'h001E);

      // Enable drop mid-frame, with a byte offered while disabled
      send(8'h05);
      send(8'h00);
      rx_data  = 8'h07;
      rx_valid = 1'b1;
      enable   = 1'b0;
      @(posedge clock);
      #1 rx_valid = 1'b0;
      enable = 1'b1;
      chk("dis_idle", 32'(busy), 32'd0);
      chk("dis_no_err", 32'(frame_err), 32'd0);
      chk("dis_no_write", 32'(write), 32'd0);
      send(8'h23);
      chk("restart_no_err", 32'(frame_err), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      send(8'h00);
      expect_write(8'h23, 16'h0001);
      send(8'h01);
      chk("restart_write", 32'(write), 32'd1);

      // Back-to-back frames
      expect_write(8'h06, 16'h0032);
      expect_write(8'h01, 16'h0019);
      send(8'h06);
      send(8'h00);
      send(8'h32);
      chk("b2b_write1", 32'(write), 32'd1);
      send(8'h01);
      chk("b2b_gap", 32'(write), 32'd0);
      send(8'h00);
      send(8'h19);
      chk("b2b_write2", 32'(write), 32'd1);
      idle(1);

      // Reset mid-frame
      send(8'h01);
      Reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b1;
      @(posedge clock);
      #1 Reset = 1'b0;
      rx_valid = 1'b0;
      exp_fc = '0;
      exp_ec = '0;
      chk("mrst_cmd", 32'(cmd), 32'd0);
      chk("mrst_value", 32'(value), 32'd0);
      chk("mrst_write", 32'(write), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_frame_count", 32'(frame_count), 32'd0);
      chk("mrst_err_count", 32'(err_count), 32'd0);
      idle(T + 3);
      chk("mrst_no_write", 32'(writes_seen), 32'(exp_writes));
      chk("mrst_no_err", 32'(errs_seen), 32'(exp_errs));

      // err_count saturates
      for (int i = 0; i < 260; i++) begin
         send(8'h0F);
         exp_errs++;
      end
      idle(1);
      chk("err_saturate", 32'(err_count), 32'h00FF);

      // frame_count wraps after 256 writes
      for (int i = 0; i < 256; i++) begin
         expect_write(8'h17, 16'h0000);
         send(8'h17);
      end
      idle(2);
      chk("frame_wrap", 32'(frame_count), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("total_writes", 32'(writes_seen), 32'(exp_writes));
      chk("total_errs", 32'(errs_seen), 32'(exp_errs));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
